// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite bus arbiter: one-hot HGRANT, burst/lock-aware handover at
// HREADY=1 edges, and HMASTER/HMASTLOCK trailing the grant by one transfer.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned MASTER_W       = 2,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                   HMASTCLOCK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MASTER_W-1:0]    HMASTER,
  output logic                   HMASTLOCK
);

  localparam int unsigned REM_W = 5;
  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [REM_W-1:0]       burst_rem_q, burst_rem_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MASTER_W-1:0]    hmaster_q, hmaster_d;
  logic                   mastlock_q, mastlock_d;
  logic [MASTER_W-1:0]    rr_last_q, rr_last_d;
  logic [MASTER_W-1:0]    grant_idx_c;
  logic [MASTER_W-1:0]    winner_c;
  logic                   win_req_c;
  logic                   locked_c;

  always_ff @(posedge HMASTCLOCK or posedge HRESET) begin
    if (HRESET) begin
      burst_rem_q <= '0;
      grant_q     <= GRANT_RST;
      hmaster_q   <= MASTER_W'(DEFAULT_MASTER);
      mastlock_q  <= 1'b0;
      rr_last_q   <= MASTER_W'(DEFAULT_MASTER);
    end else begin
      burst_rem_q <= burst_rem_d;
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      mastlock_q  <= mastlock_d;
      rr_last_q   <= rr_last_d;
    end
  end

  // Remaining beats of the current fixed-length burst after this edge
  always_comb begin
    burst_rem_d = burst_rem_q;
    if (HREADY) begin
      unique case (HTRANS)
        TR_NONSEQ: begin
          unique case (HBURST)
            3'd2, 3'd3: burst_rem_d = REM_W'(3);
            3'd4, 3'd5: burst_rem_d = REM_W'(7);
            3'd6, 3'd7: burst_rem_d = REM_W'(15);
            default:    burst_rem_d = '0;
          endcase
        end
        TR_SEQ:  burst_rem_d = (burst_rem_q != '0) ? burst_rem_q - REM_W'(1) : '0;
        TR_BUSY: burst_rem_d = burst_rem_q;
        TR_IDLE: burst_rem_d = '0;
        default: burst_rem_d = '0;
      endcase
    end
  end

  // Index of the granted master and lock state of the address-phase owner
  always_comb begin
    grant_idx_c = MASTER_W'(DEFAULT_MASTER);
    locked_c    = 1'b0;
    for (int j = 0; j < int'(NUM_MASTERS); j++) begin
      if (grant_q[j]) grant_idx_c = MASTER_W'(j);
      if (hmaster_q == MASTER_W'(j)) locked_c = HLOCK[j] & HBUSREQ[j];
    end
  end

  // Round-robin search starting after rr_last; scanning far-to-near keeps the nearest hit
  always_comb begin
    winner_c  = MASTER_W'(DEFAULT_MASTER);
    win_req_c = 1'b0;
    for (int i = int'(NUM_MASTERS); i >= 1; i--) begin
      for (int j = 0; j < int'(NUM_MASTERS); j++) begin
        if ((j == (int'(rr_last_q) + i) % int'(NUM_MASTERS)) && HBUSREQ[j]) begin
          winner_c  = MASTER_W'(j);
          win_req_c = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    hmaster_d  = hmaster_q;
    mastlock_d = mastlock_q;
    if (HREADY) begin
      hmaster_d  = grant_idx_c;
      mastlock_d = |(HLOCK & grant_q);
      if ((burst_rem_d == '0) && !locked_c) begin
        grant_d = NUM_MASTERS'(1) << winner_c;
        if (win_req_c) rr_last_d = winner_c;
      end
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_ahb_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] busreq = '0;
  logic [N-1:0] lock = '0;
  logic [1:0]   trans = 2'd0;
  logic [2:0]   burst = 3'd0;
  logic         ready = 1'b1;
  logic [N-1:0] hgrant;
  logic [1:0]   hmaster;
  logic         hmastlock;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  ahb_arbiter #(.NUM_MASTERS(4), .MASTER_W(2), .DEFAULT_MASTER(0)) dut (
    .HMASTCLOCK(clk),
    .HRESET    (rst),
    .HBUSREQ   (busreq),
    .HLOCK     (lock),
    .HTRANS    (trans),
    .HBURST    (burst),
    .HREADY    (ready),
    .HGRANT    (hgrant),
    .HMASTER   (hmaster),
    .HMASTLOCK (hmastlock)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int grant;
    int master;
    int rr;
    int rem;
    bit mlock;
  } mstate_t;

  localparam mstate_t M_RESET = '{grant: 0, master: 0, rr: 0, rem: 0, mlock: 1'b0};

  mstate_t m = M_RESET;

  // Next model state from the arbitration rules, written directly in integers
  function automatic mstate_t mstep(mstate_t s, logic [N-1:0] req, logic [N-1:0] lck,
                                    logic [1:0] tr, logic [2:0] bu, logic rdy);
    mstate_t n;
    int      nrem;
    bit      found;
    n = s;
    if (!rdy) return s;
    case (tr)
      2'd0:    nrem = 0;
      2'd1:    nrem = s.rem;
      2'd2:    nrem = (bu >= 3'd2) ? (4 << ((int'(bu) - 2) / 2)) - 1 : 0;
      default: nrem = (s.rem > 0) ? s.rem - 1 : 0;
    endcase
    n.rem    = nrem;
    n.master = s.grant;
    n.mlock  = lck[s.grant];
    if (nrem == 0 && !(lck[s.master] && req[s.master])) begin
      n.grant = 0;
      found   = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(s.rr + k) % N]) begin
          n.grant = (s.rr + k) % N;
          found   = 1'b1;
        end
      end
      if (found) n.rr = n.grant;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= M_RESET;
    else     m <= mstep(m, busreq, lock, trans, burst, ready);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_hgrant", 32'(hgrant), 32'(1 << m.grant));
      chk("model_hmaster", 32'(hmaster), 32'(m.master));
      chk("model_hmastlock", 32'(hmastlock), 32'(m.mlock));
    end
  end

  // Apply inputs at a falling edge and advance through one rising edge
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] lck,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    busreq = req; lock = lck; trans = tr; burst = bu; ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    busreq = '0; lock = '0; trans = 2'd0; burst = 3'd0; ready = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic burst_handover(input int waits);
    int first;
    first = -1;
    do_reset();
    step(4'b0010, 4'b0000, 2'd2, 3'd0, 1'b1);
    step(4'b0010, 4'b0000, 2'd2, 3'd0, 1'b1);
    chk("burst_owner_m1", 32'(hmaster), 32'd1);
    for (int e = 1; e <= 16; e++) begin
      if (e == 1)                          step(4'b0110, 4'b0000, 2'd2, 3'd3, 1'b1);
      else if (e >= 3 && e < 3 + waits)    step(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b0);
      else if (e <= 4 + waits)             step(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1);
      else                                 step(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1);
      if (first < 0 && hgrant == 4'b0100) first = e;
      if (e < 4 + waits) chk("burst_hold_m1", 32'(hgrant), 32'b0010);
    end
    if (first < 0) $display("FAIL burst_handover_timeout waits=%0d", waits);
    chk("burst_handover_edge", 32'(first), 32'(4 + waits));
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    cmp_en = 1'b1;
    chk("reset_hgrant", 32'(hgrant), 32'b0001);
    chk("reset_hmaster", 32'(hmaster), 32'd0);

    // Round-robin among M1..M3 with single transfers
    step(4'b1110, 4'b0000, 2'd2, 3'd0, 1'b1);
    chk("rr_g1", 32'(hgrant), 32'b0010); chk("rr_m1", 32'(hmaster), 32'd0);
    step(4'b1110, 4'b0000, 2'd2, 3'd0, 1'b1);
    chk("rr_g2", 32'(hgrant), 32'b0100); chk("rr_m2", 32'(hmaster), 32'd1);
    step(4'b1110, 4'b0000, 2'd2, 3'd0, 1'b1);
    chk("rr_g3", 32'(hgrant), 32'b1000); chk("rr_m3", 32'(hmaster), 32'd2);
    step(4'b1110, 4'b0000, 2'd2, 3'd0, 1'b1);
    chk("rr_g4", 32'(hgrant), 32'b0010); chk("rr_m4", 32'(hmaster), 32'd3);

    // Fixed-length burst hold, without and with wait states
    burst_handover(0);
    burst_handover(3);

    // Locked sequence by M3 while M0/M1 request
    do_reset();
    step(4'b1000, 4'b1000, 2'd2, 3'd0, 1'b1);
    step(4'b1000, 4'b1000, 2'd2, 3'd0, 1'b1);
    chk("lock_grant", 32'(hgrant), 32'b1000);
    chk("lock_master", 32'(hmaster), 32'd3);
    chk("lock_mastlock", 32'(hmastlock), 32'd1);
    step(4'b1011, 4'b1000, 2'd2, 3'd0, 1'b1);
    step(4'b1011, 4'b1000, 2'd2, 3'd0, 1'b1);
    chk("lock_hold_grant", 32'(hgrant), 32'b1000);
    chk("lock_hold_mastlock", 32'(hmastlock), 32'd1);
    step(4'b0011, 4'b0000, 2'd2, 3'd0, 1'b1);
    chk("lock_release_m0", 32'(hgrant), 32'b0001);

    // Park on default master, then M3 picks up
    do_reset();
    step(4'b0100, 4'b0000, 2'd2, 3'd0, 1'b1);
    chk("park_m2", 32'(hgrant), 32'b0100);
    step(4'b0100, 4'b0000, 2'd2, 3'd0, 1'b1);
    step(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1);
    chk("park_default", 32'(hgrant), 32'b0001);
    step(4'b0011, 4'b0000, 2'd0, 3'd0, 1'b1);
    chk("park_rr_after_m2", 32'(hgrant), 32'b0001);
    step(4'b1000, 4'b0000, 2'd2, 3'd0, 1'b1);
    chk("park_then_m3", 32'(hgrant), 32'b1000);

    // Asynchronous reset in the middle of an INCR8 burst
    step(4'b1000, 4'b0000, 2'd2, 3'd5, 1'b1);
    step(4'b1000, 4'b0000, 2'd3, 3'd5, 1'b1);
    step(4'b1000, 4'b0000, 2'd3, 3'd5, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("midburst_rst_grant", 32'(hgrant), 32'b0001);
    chk("midburst_rst_master", 32'(hmaster), 32'd0);
    chk("midburst_rst_lock", 32'(hmastlock), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    busreq = '0; trans = 2'd0; burst = 3'd0;
    @(negedge clk);
    repeat (3) step(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1);
    chk("after_rst_idle_m0", 32'(hgrant), 32'b0001);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(4'($urandom), 4'($urandom & $urandom), 2'($urandom), 3'($urandom),
             ($urandom_range(0, 9) != 0));
      end
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
